// File: rtl/dendy_pkg.sv
// dendy_pkg: shared constants and types for the Dendy CPU-side bus blocks.
//   ADDR_OAMDMA  - CPU write address that starts a sprite DMA transfer
//   ADDR_OAMDATA - PPU OAMDATA register, destination of every DMA write
//   XFER_LEN     - bytes moved per transfer (one full page)
//   IDX_W        - width of the in-page byte index
//   dma_state_t  - sprite DMA sequencer states
package dendy_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
  localparam int unsigned XFER_LEN     = 256;
  localparam int unsigned IDX_W        = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StDummy,
    StRead,
    StWrite,
    StDone
  } dma_state_t;

  // Source address inside the selected page; the index never carries into the page.
  function automatic logic [15:0] page_addr(input logic [7:0] page,
                                            input logic [IDX_W-1:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine sitting between the 6502 core and the memory/PPU decoder.
//   A CPU write to DmaReg latches a source page. At the next opcode fetch the core is
//   halted (its clock enable is gated) and 256 bytes from {page, 00..FF} are copied to
//   OamData, one read/write pair per two CPU ticks. While busy the engine owns A/D/R/W.
//
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN
//   defined   - a start on an odd CPU cycle inserts one alignment tick (514 halted ticks)
//   undefined - no alignment tick, always 513 halted ticks
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-high reset
//   ce      in   CPU tick strobe, one clock wide
//   cpu_m0  in   core is in its opcode-fetch state
//   cpu_a   in   core address
//   cpu_d   in   core write data
//   cpu_r   in   core read pulse
//   cpu_w   in   core write pulse
//   bus_i   in   read data from the memory decoder, valid on the ce tick
//   cpu_ce  out  gated tick to the core (ce & ~halt)
//   a       out  bus address (DMA when busy, else core)
//   d       out  bus write data (DMA when busy, else core)
//   r       out  bus read pulse (DMA when busy, else core)
//   w       out  bus write pulse (DMA when busy, else core)
//   busy    out  DMA owns the bus
module oam_dma
  import dendy_pkg::*;
#(
  parameter logic [15:0] DmaReg  = ADDR_OAMDMA,
  parameter logic [15:0] OamData = ADDR_OAMDATA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        cpu_m0,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_r,
  input  logic        cpu_w,
  input  logic [7:0]  bus_i,
  output logic        cpu_ce,
  output logic [15:0] a,
  output logic [7:0]  d,
  output logic        r,
  output logic        w,
  output logic        busy
);

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(XFER_LEN - 1);

  dma_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             pending_q;
  logic [7:0]       page_q;
  logic [IDX_W-1:0] idx_q;
  logic             parity_q;
  logic             dma_r_q, dma_w_q;
  logic [7:0]       dma_d_q;
  logic [15:0]      dma_a;

  logic halt;
  logic start;
  logic read_go;
  logic write_go;
  logic idx_inc;
  logic trigger;

  // The core is halted whenever DMA runs, so a write seen while busy is stray and dropped.
  assign trigger = cpu_w && (cpu_a == DmaReg) && !busy_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    halt     = 1'b0;
    start    = 1'b0;
    read_go  = 1'b0;
    write_go = 1'b0;
    idx_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Halt lands on the fetch tick itself, so the core never issues that fetch.
        if (pending_q && cpu_m0) begin
          halt = 1'b1;
          if (ce) begin
            start   = 1'b1;
            busy_d  = 1'b1;
            state_d = (AlignEn && parity_q) ? StAlign : StDummy;
          end
        end
      end
      StAlign: begin
        halt = 1'b1;
        if (ce) state_d = StDummy;
      end
      StDummy: begin
        halt = 1'b1;
        if (ce) begin
          state_d = StRead;
          read_go = 1'b1;
        end
      end
      StRead: begin
        halt = 1'b1;
        if (ce) begin
          state_d  = StWrite;
          write_go = 1'b1;
        end
      end
      StWrite: begin
        // The tick closing the last write cycle goes back to the core.
        halt = (idx_q != LastIdx);
        if (ce) begin
          idx_inc = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StDone;
            busy_d  = 1'b0;
          end else begin
            state_d = StRead;
            read_go = 1'b1;
          end
        end
      end
      StDone: begin
        if (ce) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dma_a = (state_q == StWrite) ? OamData : page_addr(page_q, idx_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      page_q    <= '0;
      idx_q     <= '0;
      parity_q  <= 1'b0;
      dma_r_q   <= 1'b0;
      dma_w_q   <= 1'b0;
      dma_d_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      // Pulses are registered one clock after the tick and always drop on the next clock.
      dma_r_q <= read_go;
      dma_w_q <= write_go;
      if (ce) parity_q <= ~parity_q;
      if (write_go) dma_d_q <= bus_i;
      if (start) begin
        pending_q <= 1'b0;
        idx_q     <= '0;
      end else begin
        if (trigger) begin
          pending_q <= 1'b1;
          page_q    <= cpu_d;
        end
        if (idx_inc) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign cpu_ce = ce & ~halt;
  assign busy   = busy_q;
  assign a      = busy_q ? dma_a   : cpu_a;
  assign d      = busy_q ? dma_d_q : cpu_d;
  assign r      = busy_q ? dma_r_q : cpu_r;
  assign w      = busy_q ? dma_w_q : cpu_w;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized self-checking bench for oam_dma.
//   A bus monitor logs every read/write pulse and counts gated CPU ticks; each scenario
//   builds the expected bus transaction list from the transfer rules and compares.
//   Honours OAM_DMA_ODD_ALIGN_EN the same way the design does.
module tb_oam_dma;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam int AlignEn = 1;
`else
  localparam int AlignEn = 0;
`endif

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        ce;
  logic        cpu_m0;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_r;
  logic        cpu_w;
  logic [7:0]  bus_i;
  logic        cpu_ce;
  logic [15:0] a;
  logic [7:0]  d;
  logic        r;
  logic        w;
  logic        busy;

  logic [15:0] mem_key;
  int          n_checks = 0;
  int          n_pass = 0;
  int          ticks = 0;
  int          last_base = 0;
  int          halted_total = 0;
  int          busy_total = 0;
  int          oam_total = 0;
  ev_t         obs_ev[$];
  int          obs_halt[$];
  ev_t         exp_ev[$];

  always #20 clock = ~clock;

  oam_dma dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .cpu_m0 (cpu_m0),
    .cpu_a  (cpu_a),
    .cpu_d  (cpu_d),
    .cpu_r  (cpu_r),
    .cpu_w  (cpu_w),
    .bus_i  (bus_i),
    .cpu_ce (cpu_ce),
    .a      (a),
    .d      (d),
    .r      (r),
    .w      (w),
    .busy   (busy)
  );

  // Memory contents as a function of address; key 0 gives data == address low byte.
  function automatic logic [7:0] mem_byte(input logic [15:0] addr, input logic [15:0] key);
    return (addr[7:0] + key[7:0]) ^ (addr[15:8] & key[15:8]);
  endfunction

  assign bus_i = mem_byte(a, mem_key);

  function automatic ev_t mk_ev(input logic wr, input logic [15:0] addr, input logic [7:0] data);
    ev_t e;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (r) begin
        obs_ev.push_back(mk_ev(1'b0, a, 8'h00));
        obs_halt.push_back(halted_total);
      end
      if (w) begin
        obs_ev.push_back(mk_ev(1'b1, a, d));
        obs_halt.push_back(halted_total);
        if (a == 16'h2004) oam_total++;
      end
      if (busy) busy_total++;
      if (ce && !cpu_ce) halted_total++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One CPU tick followed by 1..3 idle clocks; returns just after a monitor sample.
  task automatic tick(input logic m0);
    int gap;
    gap = $urandom_range(0, 2);
    @(posedge clock); #1;
    ce     = 1'b1;
    cpu_m0 = m0;
    cpu_a  = 16'($urandom);
    ticks++;
    @(posedge clock); #1;
    ce     = 1'b0;
    cpu_m0 = 1'b0;
    repeat (gap) @(posedge clock);
    @(negedge clock); #1;
  endtask

  task automatic core_write(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clock); #1;
    ce    = 1'b0;
    cpu_w = 1'b1;
    cpu_a = addr;
    cpu_d = data;
    @(posedge clock); #1;
    cpu_w = 1'b0;
    cpu_d = 8'($urandom);
  endtask

  task automatic push_pairs(input logic [7:0] page, input logic [15:0] key, input int n);
    for (int k = 0; k < n; k++) begin
      exp_ev.push_back(mk_ev(1'b0, {page, 8'(k)}, 8'h00));
      exp_ev.push_back(mk_ev(1'b1, 16'h2004, mem_byte({page, 8'(k)}, key)));
    end
  endtask

  task automatic compare_events(input string tag, input int base);
    int n_obs;
    n_obs = obs_ev.size() - base;
    check_eq({tag, "_nev"}, n_obs, exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < n_obs; i++)
      check_eq($sformatf("%s_ev%0d", tag, i), 32'(obs_ev[base + i]), 32'(exp_ev[i]));
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] page, input bit odd,
                          input logic [15:0] key);
    int h0;
    int first_h;
    int exp_halt;
    mem_key   = key;
    last_base = obs_ev.size();
    h0        = halted_total;
    exp_ev.delete();
    core_write(16'h4014, page);
    exp_ev.push_back(mk_ev(1'b1, 16'h4014, page));
    if ((ticks % 2) != int'(odd)) tick(1'b0);
    tick(1'b1);
    repeat (530) tick(1'b0);
    push_pairs(page, key, 256);
    exp_halt = 513 + ((odd && AlignEn != 0) ? 1 : 0);
    check_eq({tag, "_halted"}, halted_total - h0, exp_halt);
    first_h = -1;
    for (int i = last_base; i < obs_ev.size(); i++) begin
      if (!obs_ev[i].wr) begin
        first_h = obs_halt[i] - h0;
        break;
      end
    end
    check_eq({tag, "_first_rd_tick"}, first_h, 2 + ((odd && AlignEn != 0) ? 1 : 0));
    compare_events(tag, last_base);
  endtask

  task automatic test_reset_mid();
    int          base;
    int          h0;
    int          o0;
    int          n;
    logic [7:0]  page;
    logic [15:0] key;
    page    = 8'($urandom);
    key     = 16'($urandom);
    mem_key = key;
    base    = obs_ev.size();
    o0      = oam_total;
    exp_ev.delete();
    core_write(16'h4014, page);
    exp_ev.push_back(mk_ev(1'b1, 16'h4014, page));
    tick(1'b1);
    n = 0;
    while ((oam_total - o0) < 100 && n < 600) begin
      tick(1'b0);
      n++;
    end
    check_eq("t5_reach100", oam_total - o0, 100);
    @(posedge clock); #1;
    reset = 1'b1;
    ce    = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    ce    = 1'($urandom);
    cpu_a = 16'($urandom);
    ticks = int'(ce);
    @(negedge clock);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_w", w, 1'b0);
    check_eq("t5_r", r, 1'b0);
    check_eq("t5_cpu_ce", cpu_ce, ce);
    check_eq("t5_a", a, cpu_a);
    @(posedge clock); #1;
    ce = 1'b0;
    h0 = halted_total;
    repeat (600) tick(1'($urandom));
    check_eq("t5_halted_after", halted_total - h0, 0);
    check_eq("t5_oam_writes", oam_total - o0, 100);
    push_pairs(page, key, 100);
    compare_events("t5", base);
  endtask

  task automatic test_no_trigger();
    int         base;
    int         h0;
    int         b0;
    logic [7:0] v1;
    logic [7:0] v2;
    base = obs_ev.size();
    h0   = halted_total;
    b0   = busy_total;
    v1   = 8'($urandom);
    v2   = 8'($urandom);
    exp_ev.delete();
    core_write(16'h4015, v1);
    core_write(16'h4013, v2);
    exp_ev.push_back(mk_ev(1'b1, 16'h4015, v1));
    exp_ev.push_back(mk_ev(1'b1, 16'h4013, v2));
    repeat (20) tick(1'b1);
    check_eq("t6_halted", halted_total - h0, 0);
    check_eq("t6_busy", busy_total - b0, 0);
    compare_events("t6", base);
  endtask

  initial begin
    int last_rd;
    int n_zero;
    reset   = 1'b1;
    ce      = 1'b0;
    cpu_m0  = 1'b0;
    cpu_r   = 1'b0;
    cpu_w   = 1'b0;
    cpu_a   = 16'h0000;
    cpu_d   = 8'h00;
    mem_key = 16'h0000;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    ce    = 1'b1;
    cpu_a = 16'h1234;
    cpu_d = 8'h5a;
    @(negedge clock);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cpu_ce", cpu_ce, 1'b1);
    check_eq("rst_a", a, 16'h1234);
    check_eq("rst_d", d, 8'h5a);
    check_eq("rst_r", r, 1'b0);
    check_eq("rst_w", w, 1'b0);
    ticks = 1;
    @(posedge clock); #1;
    ce = 1'b0;

    run_xfer("t1_even", 8'h02, 1'b0, 16'($urandom));
    run_xfer("t2_odd", 8'h02, 1'b1, 16'($urandom));

    run_xfer("t4_pageff", 8'hFF, 1'b0, 16'h0000);
    last_rd = -1;
    n_zero  = 0;
    for (int i = last_base; i < obs_ev.size(); i++) begin
      if (!obs_ev[i].wr) begin
        last_rd = int'(obs_ev[i].addr);
        if (obs_ev[i].addr == 16'h0000) n_zero++;
      end
    end
    check_eq("t4_last_rd", last_rd, 16'hFFFF);
    check_eq("t4_rd_0000", n_zero, 0);

    for (int i = 0; i < 2; i++)
      run_xfer($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom), 16'($urandom));

    test_reset_mid();
    test_no_trigger();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
